// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: takes one request from execute, performs a single
// data-memory load/store or forwards the ALU value, and holds the result for write-back.
module mem_access_unit #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [15:0]      in_addr,
    input  logic [15:0]      in_wdata,
    input  logic [15:0]      in_alu,
    input  logic [3:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [3:0]       out_rd,
    output logic             out_wen,
    output logic             out_fault,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             mem_read,
    output logic             mem_load,
    input  logic [15:0]      mem_rdata,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt,
    output logic [CNT_W-1:0] fault_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]  state;
    logic [1:0]  req_op;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [15:0] req_alu;
    logic [3:0]  req_rd;

    logic in_access;
    logic addr_oob;
    logic req_fault;
    logic good_load;
    logic good_store;

    assign in_access  = (state == ACCESS);
    assign addr_oob   = ({16'd0, req_addr} >= DEPTH[31:0]);
    assign req_fault  = (req_op == OP_ILL) ||
                        (((req_op == OP_LOAD) || (req_op == OP_STORE)) && addr_oob);
    assign good_load  = (req_op == OP_LOAD)  && !req_fault;
    assign good_store = (req_op == OP_STORE) && !req_fault;

    always_comb begin
        case (state)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Clear gates the strobes so a store caught mid-access never reaches memory.
    assign mem_read  = in_access && good_load  && !clear;
    assign mem_load  = in_access && good_store && !clear;
    assign mem_addr  = in_access ? req_addr  : 16'd0;
    assign mem_wdata = in_access ? req_wdata : 16'd0;

    always_ff @(posedge clk) begin
        if (clear) begin
            req_op    <= OP_PASS;
            req_addr  <= 16'd0;
            req_wdata <= 16'd0;
            req_alu   <= 16'd0;
            req_rd    <= 4'd0;
        end else if (in_valid && in_ready) begin
            req_op    <= in_op;
            req_addr  <= in_addr;
            req_wdata <= in_wdata;
            req_alu   <= in_alu;
            req_rd    <= in_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= 16'd0;
            out_rd    <= 4'd0;
            out_wen   <= 1'b0;
            out_fault <= 1'b0;
            load_cnt  <= '0;
            store_cnt <= '0;
            fault_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) state <= ACCESS;
                end
                ACCESS: begin
                    out_valid <= 1'b1;
                    out_rd    <= req_rd;
                    out_fault <= req_fault;
                    if (req_fault) begin
                        out_data <= 16'd0;
                        out_wen  <= 1'b0;
                        if (fault_cnt != CNT_MAX) fault_cnt <= fault_cnt + 1'b1;
                    end else if (req_op == OP_LOAD) begin
                        out_data <= mem_rdata;
                        out_wen  <= 1'b1;
                        if (load_cnt != CNT_MAX) load_cnt <= load_cnt + 1'b1;
                    end else if (req_op == OP_STORE) begin
                        out_data <= 16'd0;
                        out_wen  <= 1'b0;
                        if (store_cnt != CNT_MAX) store_cnt <= store_cnt + 1'b1;
                    end else begin
                        out_data <= req_alu;
                        out_wen  <= 1'b1;
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    // Result consumed; a waiting request goes straight into ACCESS.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= in_valid ? ACCESS : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of data-memory words; valid word addresses are 0..DEPTH-1.
REQ-002 SHALL have parameter CNT_W, default 8: width of each statistics counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: request present from execute stage.
REQ-006 SHALL have port in_ready, output, 1: unit accepts a request this cycle.
REQ-007 SHALL have port in_op, input, 2: 00 pass, 01 load, 10 store, 11 illegal.
REQ-008 SHALL have port in_addr, input, 16: word address.
REQ-009 SHALL have port in_wdata, input, 16: store data.
REQ-010 SHALL have port in_alu, input, 16: ALU result forwarded on a pass op.
REQ-011 SHALL have port in_rd, input, 4: destination register tag.
REQ-012 SHALL have port out_valid, output, 1: result present for write-back.
REQ-013 SHALL have port out_ready, input, 1: write-back consumes the result.
REQ-014 SHALL have ports out_data (output, 16), out_rd (output, 4), out_wen (output, 1) and out_fault (output, 1): write-back value, destination tag, register-write enable and fault flag.
REQ-015 SHALL have ports mem_addr (output, 16), mem_wdata (output, 16), mem_read (output, 1), mem_load (output, 1) and mem_rdata (input, 16): data-memory address, write data, read enable, write enable and asynchronous read data.
REQ-016 SHALL have ports load_cnt, store_cnt and fault_cnt, each output, CNT_W: statistics counters.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCESS and HOLD.
REQ-018 SHALL, in IDLE, drive in_ready=1 and, on in_valid, latch op, addr, wdata, alu and rd into request registers and move to ACCESS.
REQ-019 SHALL, in ACCESS, drive in_ready=0, load the output registers at the clock edge, set out_valid=1 and move to HOLD.
REQ-020 SHALL, in HOLD, drive in_ready=out_ready and hold all out_* stable while out_ready=0.
REQ-021 SHALL, in HOLD with out_ready=1, latch a new request and move to ACCESS if in_valid=1, otherwise move to IDLE; sustained throughput is one request per 2 cycles.
REQ-022 SHALL flag a fault when op=11, or when op is load/store and in_addr>=DEPTH.
REQ-023 SHALL drive mem_read=1 only in ACCESS for a non-faulting load.
REQ-024 SHALL drive mem_load=1 only in ACCESS for a non-faulting store with clear=0, for exactly one cycle per store.
REQ-025 SHALL drive mem_addr and mem_wdata from the request registers in ACCESS and 0 in all other states.
REQ-026 SHALL, for a load result, produce out_data=mem_rdata sampled in ACCESS, out_wen=1.
REQ-027 SHALL, for a store result, produce out_data=0, out_wen=0.
REQ-028 SHALL, for a pass result, produce out_data=latched alu, out_wen=1.
REQ-029 SHALL, for a faulting request, produce out_data=0, out_wen=0, out_fault=1 and perform no memory access; out_fault SHALL be 0 for every other result.
REQ-030 SHALL set out_rd to the latched rd for every result.
REQ-031 SHALL, in ACCESS, increment load_cnt for a non-faulting load, store_cnt for a non-faulting store and fault_cnt for a fault, each saturating at 2^CNT_W-1 with no wrap.
REQ-032 SHALL ignore input fields while in_ready=0; no request is lost or duplicated under back-pressure.

Reset
REQ-033 SHALL, with clear=1 at a clock edge, enter IDLE and zero out_valid, out_data, out_rd, out_wen, out_fault and all counters; clear has priority over every other event.
REQ-034 SHALL, while clear=1, drive mem_read=0 and mem_load=0, so that a store in ACCESS never writes memory and the request is discarded.
REQ-035 SHALL, in the cycle after clear deasserts, drive in_ready=1 (IDLE).

Verification
REQ-036 Load: memory word 3 holds 6; send op=01, addr=3, rd=5 -> mem_read high for 1 cycle with mem_addr=3; 2 cycles later out_valid=1, out_data=6, out_rd=5, out_wen=1; load_cnt=1.
REQ-037 Store then load: store 0x00AA to addr 10, then load addr 10 -> mem_load pulses once; load returns 0x00AA; store result out_wen=0.
REQ-038 Fault: load addr 64, then op=11 -> no mem_read/mem_load; both results out_fault=1, out_wen=0; fault_cnt=2.
REQ-039 Back-pressure: out_ready=0 for 5 cycles in HOLD with in_valid=1 -> out_* stable, in_ready=0; release -> next request enters ACCESS in the same edge.
REQ-040 Clear mid-store: clear=1 during ACCESS of a store to addr 2 -> mem_load=0; memory word 2 unchanged; next cycle state IDLE, out_valid=0, counters 0.
REQ-041 Saturation: issue 260 pass-free loads -> load_cnt stops at 255.
